// File: rtl/ctrl_unit_if.sv
// Instruction ROM input and datapath control bus between ctrl_unit (master)
// and the surrounding datapath (slave).
interface ctrl_unit_if;
    logic [15:0] IR_in;
    logic        PC_clr;
    logic        PC_up;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic        Halt;
    logic        Illegal;
    logic [3:0]  State;

    modport master (
        input  IR_in,
        output PC_clr, PC_up, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, Halt, Illegal, State
    );

    modport slave (
        output IR_in,
        input  PC_clr, PC_up, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, Halt, Illegal, State
    );
endinterface

// File: rtl/ctrl_unit.sv
// Moore instruction-sequencing FSM driving PC, data memory, register file and ALU.
// Define ILLEGAL_TRAP_EN to halt (with Illegal=1) on opcodes 6-15 instead of treating them as NOOP.
module ctrl_unit (
    input  logic        Clock,
    input  logic        Clr,
    ctrl_unit_if.master bus
);
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOAD_A = 4'd3,
        LOAD_B = 4'd4,
        STORE  = 4'd5,
        ADD    = 4'd6,
        SUB    = 4'd7,
        NOOP   = 4'd8,
        HALT   = 4'd9
    } state_t;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_up;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       halt;
        logic       illegal;
    } ctl_t;

    state_t      state, state_nx;
    logic [15:0] ir, ir_nx;
    ctl_t        ctl, ctl_nx;

    // Outputs are a pure function of (state, IR); evaluating it on the next
    // state/IR lets them be registered without adding a cycle of lag.
    function automatic ctl_t decode(state_t s, logic [15:0] i);
        ctl_t c;
        c = '0;
        case (s)
            INIT:  c.pc_clr = 1'b1;
            FETCH: c.pc_up  = 1'b1;
            LOAD_A, LOAD_B: begin
                c.d_addr = i[7:0];
                c.rf_s   = 1'b1;
                c.w_addr = i[11:8];
                c.w_en   = (s == LOAD_B);
            end
            STORE: begin
                c.d_addr = i[7:0];
                c.ra     = i[11:8];
                c.d_wr   = 1'b1;
            end
            ADD, SUB: begin
                c.ra     = i[7:4];
                c.rb     = i[3:0];
                c.w_addr = i[11:8];
                c.w_en   = 1'b1;
                c.alu    = (s == ADD) ? 3'd1 : 3'd2;
            end
            HALT: begin
                c.halt = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                c.illegal = (i[15:12] > 4'd5);
`else
                c.illegal = 1'b0;
`endif
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nx = INIT;
        ir_nx    = ir;
        case (state)
            INIT:   state_nx = FETCH;
            FETCH: begin
                state_nx = DECODE;
                ir_nx    = bus.IR_in;
            end
            DECODE: begin
                case (ir[15:12])
                    4'd0:    state_nx = LOAD_A;
                    4'd1:    state_nx = STORE;
                    4'd2:    state_nx = ADD;
                    4'd3:    state_nx = SUB;
                    4'd4:    state_nx = NOOP;
                    4'd5:    state_nx = HALT;
`ifdef ILLEGAL_TRAP_EN
                    default: state_nx = HALT;
`else
                    default: state_nx = NOOP;
`endif
                endcase
            end
            LOAD_A: state_nx = LOAD_B;
            LOAD_B, STORE, ADD, SUB, NOOP: state_nx = FETCH;
            HALT:   state_nx = HALT;
            default: state_nx = INIT;
        endcase
        ctl_nx = decode(state_nx, ir_nx);
    end

    always_ff @(posedge Clock) begin
        if (Clr) begin
            state <= INIT;
            ir    <= '0;
            ctl   <= decode(INIT, 16'h0000);
        end else begin
            state <= state_nx;
            ir    <= ir_nx;
            ctl   <= ctl_nx;
        end
    end

    assign bus.PC_clr     = ctl.pc_clr;
    assign bus.PC_up      = ctl.pc_up;
    assign bus.D_addr     = ctl.d_addr;
    assign bus.D_wr       = ctl.d_wr;
    assign bus.RF_s       = ctl.rf_s;
    assign bus.RF_W_addr  = ctl.w_addr;
    assign bus.RF_W_en    = ctl.w_en;
    assign bus.RF_Ra_addr = ctl.ra;
    assign bus.RF_Rb_addr = ctl.rb;
    assign bus.ALU_s0     = ctl.alu;
    assign bus.Halt       = ctl.halt;
    assign bus.Illegal    = ctl.illegal;
    assign bus.State      = state;
endmodule

// File: tb/tb_ctrl_unit.sv
// Directed-vector bench for ctrl_unit; IR_in is driven directly by the bench.
module tb_ctrl_unit;
    logic Clock;
    logic Clr;
    int   errors = 0;
    int   checks = 0;
    int   pulses;
    int   halted;

    ctrl_unit_if bus ();

    ctrl_unit dut (
        .Clock (Clock),
        .Clr   (Clr),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Clr       = 1'b1;
        bus.IR_in = 16'h0000;
        tick();
        chk("rst_state", 32'(bus.State), 0);
        chk("rst_pc_clr", 32'(bus.PC_clr), 1);
        chk("rst_pc_up", 32'(bus.PC_up), 0);
        chk("rst_strobes", {bus.D_wr, bus.RF_W_en, bus.Halt, bus.Illegal}, 0);

        // LOAD R3 <- M[0x12]
        Clr       = 1'b0;
        bus.IR_in = 16'h0312;
        tick();
        chk("fetch_state", 32'(bus.State), 1);
        chk("fetch_pc_up", 32'(bus.PC_up), 1);
        chk("fetch_pc_clr", 32'(bus.PC_clr), 0);
        tick();
        chk("dec_state", 32'(bus.State), 2);
        chk("dec_quiet", {bus.PC_up, bus.D_wr, bus.RF_W_en, bus.RF_s, bus.D_addr}, 0);
        bus.IR_in = 16'hFFFF;
        tick();
        chk("lda_state", 32'(bus.State), 3);
        chk("lda_ctl", {bus.D_addr, bus.RF_s, bus.RF_W_en, bus.RF_W_addr}, {8'h12, 1'b1, 1'b0, 4'd3});
        tick();
        chk("ldb_state", 32'(bus.State), 4);
        chk("ldb_ctl", {bus.D_addr, bus.RF_s, bus.RF_W_en, bus.RF_W_addr}, {8'h12, 1'b1, 1'b1, 4'd3});

        // ADD R10 = R5 + R12
        bus.IR_in = 16'h2A5C;
        tick();
        chk("ld_to_fetch", 32'(bus.State), 1);
        tick();
        bus.IR_in = 16'h0000;
        tick();
        chk("add_state", 32'(bus.State), 6);
        chk("add_ctl", {bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.ALU_s0, bus.RF_W_en, bus.RF_s},
            {4'd5, 4'd12, 4'd10, 3'd1, 1'b1, 1'b0});

        // STORE M[0x04] <- R7
        bus.IR_in = 16'h1704;
        tick();
        chk("add_to_fetch", 32'(bus.State), 1);
        tick();
        tick();
        chk("st_state", 32'(bus.State), 5);
        chk("st_ctl", {bus.D_wr, bus.D_addr, bus.RF_Ra_addr, bus.RF_W_en}, {1'b1, 8'h04, 4'd7, 1'b0});

        // SUB R1 = R2 - R3
        bus.IR_in = 16'h3123;
        tick();
        chk("st_wr_drop", {bus.State, bus.D_wr}, {4'd1, 1'b0});
        tick();
        tick();
        chk("sub_state", 32'(bus.State), 7);
        chk("sub_ctl", {bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.ALU_s0, bus.RF_W_en},
            {4'd2, 4'd3, 4'd1, 3'd2, 1'b1});

        // 130 NOOPs then HALT: count PC_up pulses across the whole run
        bus.IR_in = 16'h4000;
        pulses    = 0;
        for (int n = 0; n < 130; n++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                if (bus.PC_up) pulses++;
            end
        end
        chk("noop_state", 32'(bus.State), 8);
        bus.IR_in = 16'h5000;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.PC_up) pulses++;
        end
        chk("halt_state", 32'(bus.State), 9);
        chk("halt_flags", {bus.Halt, bus.Illegal}, {1'b1, 1'b0});
        halted = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.PC_up) pulses++;
            if (bus.Halt && bus.State == 4'd9) halted++;
        end
        chk("pc_up_pulses", 32'(pulses), 131);
        chk("halt_held", 32'(halted), 20);
        Clr = 1'b1;
        tick();
        chk("halt_clr", {bus.State, bus.Halt, bus.PC_clr}, {4'd0, 1'b0, 1'b1});

        // Clr mid-LOAD aborts before the register-file write
        Clr       = 1'b0;
        bus.IR_in = 16'h0312;
        tick();
        tick();
        tick();
        chk("mid_ld_state", 32'(bus.State), 3);
        Clr = 1'b1;
        tick();
        chk("mid_ld_clr", {bus.State, bus.RF_W_en, bus.RF_s, bus.D_addr}, {4'd0, 1'b0, 1'b0, 8'h00});

        // Opcode 15
        Clr       = 1'b0;
        bus.IR_in = 16'hF000;
        tick();
        chk("ill_fetch", 32'(bus.State), 1);
        tick();
        tick();
`ifdef ILLEGAL_TRAP_EN
        chk("ill_trap", {bus.State, bus.Halt, bus.Illegal}, {4'd9, 1'b1, 1'b1});
        tick();
        chk("ill_hold", {bus.State, bus.Halt, bus.Illegal}, {4'd9, 1'b1, 1'b1});
`else
        chk("ill_noop", {bus.State, bus.Halt, bus.Illegal}, {4'd8, 1'b0, 1'b0});
        tick();
        chk("ill_refetch", {bus.State, bus.PC_up}, {4'd1, 1'b1});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
